// File: rtl/datapath_decode_if.sv
// Fetch/decode boundary bundle: the IF_ID register and fetch controls coming in,
// and the fetch redirect, register-file read addresses and ID_EX going out.
interface datapath_decode_if #(
  parameter int unsigned IF_ID_WIDTH = 32,
  parameter int unsigned ID_EX_WIDTH = 64
);
  logic [IF_ID_WIDTH-1:0] IF_ID;
  logic [15:0]            instr;
  logic                   f_valid;
  logic                   flush;
  logic                   stall;
  logic [15:0]            BT;
  logic                   taken;
  logic [2:0]             rf_addr_a;
  logic [2:0]             rf_addr_b;
  logic [ID_EX_WIDTH-1:0] ID_EX;

  modport master (
    output IF_ID, instr, f_valid, flush,
    input  stall, BT, taken, rf_addr_a, rf_addr_b, ID_EX
  );

  modport slave (
    input  IF_ID, instr, f_valid, flush,
    output stall, BT, taken, rf_addr_a, rf_addr_b, ID_EX
  );
endinterface

// File: rtl/datapath_decode.sv
// Instruction-decode stage: decodes IF_ID into ID_EX, resolves j/call locally,
// inserts one bubble on a load-use hazard and squashes wrong-path words.
module datapath_decode (
  input  logic                    clk,
  input  logic                    reset,
  datapath_decode_if.slave        bus
);
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned HOLD_W  = 32;
  localparam int unsigned OP_W    = 5;

  localparam logic [OP_W-1:0] OP_MV    = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b00001;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b00010;
  localparam logic [OP_W-1:0] OP_CMP   = 5'b00011;
  localparam logic [OP_W-1:0] OP_LD    = 5'b00100;
  localparam logic [OP_W-1:0] OP_ST    = 5'b00101;
  localparam logic [OP_W-1:0] OP_JR    = 5'b01000;
  localparam logic [OP_W-1:0] OP_JZR   = 5'b01001;
  localparam logic [OP_W-1:0] OP_JNR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_CALLR = 5'b01100;
  localparam logic [OP_W-1:0] OP_MVI   = 5'b10000;
  localparam logic [OP_W-1:0] OP_ADDI  = 5'b10001;
  localparam logic [OP_W-1:0] OP_SUBI  = 5'b10010;
  localparam logic [OP_W-1:0] OP_CMPI  = 5'b10011;
  localparam logic [OP_W-1:0] OP_MVHI  = 5'b10110;
  localparam logic [OP_W-1:0] OP_J     = 5'b11000;
  localparam logic [OP_W-1:0] OP_JZ    = 5'b11001;
  localparam logic [OP_W-1:0] OP_JN    = 5'b11010;
  localparam logic [OP_W-1:0] OP_CALL  = 5'b11100;

  typedef struct packed {
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] instr;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [OP_W-1:0]   op;
    logic              wb_en;
    logic              mem_rd;
    logic              mem_wr;
    logic              is_branch;
    logic              valid;
  } id_ex_t;

  typedef enum logic [1:0] {RUN, STALL, SQUASH} state_e;

  state_e            state_q, state_d;
  id_ex_t            id_ex_q, id_ex_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] bt_q, bt_d;
  logic              taken_q, taken_d;
  logic              stall_c;

  logic [WORD_W-1:0] w, npc;
  logic [OP_W-1:0]   op;
  logic [WORD_W-1:0] jmp_off;
  logic              direct_jmp, no_src, hazard;
  logic              unused_if_id;

  // Full decode of one word into an ID_EX entry.
  function automatic id_ex_t decode(input logic [WORD_W-1:0] iw, input logic [WORD_W-1:0] pc);
    id_ex_t r;
    r           = '0;
    r.npc       = pc;
    r.instr     = iw;
    r.rx        = iw[7:5];
    r.ry        = iw[10:8];
    r.op        = iw[4:0];
    r.valid     = 1'b1;
    unique case (iw[4:0])
      OP_MV, OP_ADD, OP_SUB, OP_LD: r.wb_en = 1'b1;
      OP_CMP:                       r.wb_en = 1'b0;
      OP_ST:                        r.mem_wr = 1'b1;
      OP_JR, OP_JZR, OP_JNR:        r.is_branch = 1'b1;
      OP_CALLR: begin
        r.is_branch = 1'b1;
        r.wb_en     = 1'b1;
        r.rx        = 3'd7;
      end
      OP_MVI, OP_ADDI, OP_SUBI: begin
        r.imm   = {{8{iw[15]}}, iw[15:8]};
        r.wb_en = 1'b1;
      end
      OP_CMPI: r.imm = {{8{iw[15]}}, iw[15:8]};
      OP_MVHI: begin
        r.imm   = {iw[15:8], 8'h00};
        r.wb_en = 1'b1;
      end
      OP_J, OP_JZ, OP_JN: begin
        r.imm       = {{4{iw[15]}}, iw[15:5], 1'b0};
        r.is_branch = 1'b1;
      end
      OP_CALL: begin
        r.imm       = {{4{iw[15]}}, iw[15:5], 1'b0};
        r.is_branch = 1'b1;
        r.wb_en     = 1'b1;
        r.rx        = 3'd7;
      end
      default: ;
    endcase
    r.mem_rd = (iw[4:0] == OP_LD);
    return r;
  endfunction

  assign unused_if_id = ^bus.IF_ID[15:0];

  // Active word: the held copy while replaying a stalled instruction.
  assign w          = (state_q == STALL) ? hold_q[15:0]  : bus.instr;
  assign npc        = (state_q == STALL) ? hold_q[31:16] : bus.IF_ID[31:16];
  assign op         = w[4:0];
  assign jmp_off    = {{4{w[15]}}, w[15:5], 1'b0};
  assign direct_jmp = (op == OP_J) || (op == OP_CALL);
  assign no_src     = (op == OP_J) || (op == OP_JZ) || (op == OP_JN) ||
                      (op == OP_CALL) || (op == OP_MVI);
  assign hazard     = (state_q == RUN) && bus.f_valid && !no_src &&
                      id_ex_q.valid && id_ex_q.mem_rd &&
                      ((id_ex_q.rx == w[7:5]) || (id_ex_q.rx == w[10:8]));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    id_ex_d = '0;
    bt_d    = bt_q;
    taken_d = 1'b0;
    stall_c = 1'b0;
    if (bus.flush) begin
      state_d = RUN;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (!bus.f_valid) begin
            state_d = RUN;
          end else if (hazard) begin
            stall_c = 1'b1;
            hold_d  = {bus.IF_ID[31:16], bus.instr};
            state_d = STALL;
          end else begin
            id_ex_d = decode(w, npc);
            if (direct_jmp) begin
              bt_d    = npc + jmp_off;
              taken_d = 1'b1;
              state_d = SQUASH;
            end
          end
        end
        STALL: begin
          id_ex_d = decode(w, npc);
          state_d = RUN;
          if (direct_jmp) begin
            bt_d    = npc + jmp_off;
            taken_d = 1'b1;
            state_d = SQUASH;
          end
        end
        SQUASH:  state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      id_ex_q <= '0;
      hold_q  <= '0;
      bt_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_ex_q <= id_ex_d;
      hold_q  <= hold_d;
      bt_q    <= bt_d;
      taken_q <= taken_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign bus.stall     = reset & stall_c;
  assign bus.rf_addr_a = reset ? w[7:5]  : 3'd0;
  assign bus.rf_addr_b = reset ? w[10:8] : 3'd0;
  assign bus.BT        = bt_q;
  assign bus.taken     = taken_q;
  assign bus.ID_EX     = id_ex_q;
endmodule
